mmio_poll_waiter: RTL and testbench
===================================

// Module: mmio_poll_waiter
// PURPOSE
//   Parametrised, multi-channel successor of the single-address status-poll helper beside EX.
//   EX arms a wait on one of NUM_CH memory-mapped peripheral status words.
//   The unit captures the destination register from the triggering store, then snoops EX loads
//   of that status word until a selected bit reaches a selected polarity, or a cycle timeout expires.
//   It then returns ready (or timeout) plus the captured register address to EX.
// PARAMETERS
//   NUM_CH      4              number of peripheral channels (>=1)
//   ADDR_W      32             memory address width
//   DATA_W      32             memory data width
//   REG_ADDR_W  5              register-file address width
//   TMO_W       16             timeout counter width
//   BASE_ADDR   32'h7004_0000  status address of channel 0
//   CH_STRIDE   32'h0000_0100  address step between channels
// PORTS
//   clk           in   1               clock, rising edge
//   rst           in   1               asynchronous reset, active-high
//   start_i       in   1               arm request; sampled only in IDLE
//   abort_i       in   1               cancel current wait
//   ch_sel_i      in   CH_W            channel, CH_W = max(1,$clog2(NUM_CH))
//   done_bit_i    in   $clog2(DATA_W)  status bit index to test
//   done_pol_i    in   1               bit value that means "done"
//   tmo_i         in   TMO_W           timeout in WAIT cycles; 0 = never time out
//   mem_req_i     in   1               EX memory access valid
//   mem_we_i      in   1               1 = store, 0 = load
//   mem_addr_i    in   ADDR_W          EX access address
//   mem_rdata_i   in   DATA_W          load data for the current access
//   reg_waddr_i   in   REG_ADDR_W      EX destination register of the current instruction
//   busy_o        out  1               wait in progress (ARM or WAIT)
//   ready_o       out  1               1-cycle pulse: done condition seen
//   tmo_o         out  1               1-cycle pulse: timeout expired
//   reg_waddr_o   out  REG_ADDR_W      captured destination register; held until next start
//   ch_o          out  CH_W            channel of the current/last wait
// BEHAVIOUR
//   Reset (async, any time incl. mid-wait): state=IDLE; all outputs 0; counter and latches 0.
//   Channel address: A = BASE_ADDR + ch*CH_STRIDE, computed at ADDR_W, wrap-around ignored.
//   hit_wr = mem_req_i & mem_we_i & (mem_addr_i==A); hit_rd = mem_req_i & ~mem_we_i & (mem_addr_i==A).
//   match  = hit_rd & (mem_rdata_i[bit]==pol).
//   FSM states: IDLE, ARM, WAIT, DONE, TOUT. Outputs are registered state decodes:
//     busy_o = ARM|WAIT; ready_o = DONE; tmo_o = TOUT.
//   IDLE: on start_i & ~abort_i, latch ch/bit/pol/tmo, go to ARM. ch_sel_i>=NUM_CH is clamped to NUM_CH-1.
//   ARM: on hit_wr, latch reg_waddr_o <= reg_waddr_i, clear cnt, go to WAIT.
//     Loads and non-matching stores are ignored.
//   WAIT, priority order:
//     abort_i -> IDLE.
//     match -> DONE.
//     hit_wr -> re-latch reg_waddr_o, clear cnt, stay in WAIT.
//     tmo!=0 & cnt==tmo-1 -> TOUT.
//     otherwise cnt <= cnt+1 (saturates at all-ones when tmo==0).
//   Match and timeout expiry in the same cycle: match wins. Abort beats everything.
//   DONE, TOUT: last exactly 1 cycle, then IDLE. start_i is ignored in these states.
//   abort_i in ARM -> IDLE with no pulse. abort_i in IDLE has no effect.
//   start_i outside IDLE is ignored; latched parameters stay stable until the next IDLE start.
//   Latency: the matching load at edge N gives ready_o=1 in cycle N+1.
//     With tmo=T and no match, tmo_o rises T cycles after WAIT is entered.
// TESTING
//   1. ch=0, bit=0, pol=0, tmo=0. Store to 0x7004_0000 with rd=5, then loads returning 1,1,0
//      -> ready_o pulses 1 cycle after the third load; reg_waddr_o=5; busy_o falls with ready.
//   2. ch=2, bit=7, pol=1. Store to 0x7004_0200 with rd=9; loads of 0x7004_0000 returning 0x80
//      are ignored; load of 0x7004_0200 returning 0x80 -> ready_o, reg_waddr_o=9, ch_o=2.
//   3. tmo=3, armed and stored, loads never match -> tmo_o pulses 3 cycles after WAIT entry;
//      ready_o stays 0.
//   4. tmo=3, match on the cycle cnt==2 -> ready_o=1, tmo_o=0 (match wins).
//   5. abort_i in ARM and again in WAIT -> IDLE next cycle, busy_o=0, no ready/tmo pulse;
//      start_i during WAIT has no effect.
//   6. rst asserted asynchronously mid-WAIT -> all outputs 0 immediately;
//      after release a new start/store/match completes normally.

Source files
------------

// File: rtl/mmio_poll_waiter.sv
// mmio_poll_waiter
//   Multi-channel status-poll helper that sits beside EX. A start request arms a
//   wait on one of NUM_CH memory-mapped status words. The first EX store to that
//   word captures the destination register. EX loads of the word are then snooped
//   until a chosen bit reaches a chosen polarity, or until a cycle timeout expires.
//   The unit reports the outcome together with the captured register address.
//
// Ports
//   clk, rst        clock (rising edge) and asynchronous active-high reset
//   start_i         arm request; only sampled in IDLE
//   abort_i         cancel the wait in progress
//   ch_sel_i        channel to watch; values >= NUM_CH are clamped to NUM_CH-1
//   done_bit_i      index of the status bit to test
//   done_pol_i      bit value that means "done"
//   tmo_i           timeout in WAIT cycles; 0 means never time out
//   mem_req_i       EX memory access valid
//   mem_we_i        1 = store, 0 = load
//   mem_addr_i      EX access address
//   mem_rdata_i     load data for the current access
//   reg_waddr_i     EX destination register of the current instruction
//   busy_o          wait in progress (ARM or WAIT)
//   ready_o         one-cycle pulse: done condition seen
//   tmo_o           one-cycle pulse: timeout expired
//   reg_waddr_o     captured destination register
//   ch_o            channel of the current or last wait
//
// Handshake: there is no back-pressure. start_i is a request that takes effect
// only in IDLE. ready_o and tmo_o are single-cycle pulses, and they are never
// asserted together. The consumer must act on a pulse in the cycle it appears.
module mmio_poll_waiter #(
    parameter int                NUM_CH     = 4,
    parameter int                ADDR_W     = 32,
    parameter int                DATA_W     = 32,
    parameter int                REG_ADDR_W = 5,
    parameter int                TMO_W      = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = 32'h7004_0000,
    parameter logic [ADDR_W-1:0] CH_STRIDE  = 32'h0000_0100,
    localparam int               CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int               BIT_W      = $clog2(DATA_W)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic                  abort_i,
    input  logic [CH_W-1:0]       ch_sel_i,
    input  logic [BIT_W-1:0]      done_bit_i,
    input  logic                  done_pol_i,
    input  logic [TMO_W-1:0]      tmo_i,
    input  logic                  mem_req_i,
    input  logic                  mem_we_i,
    input  logic [ADDR_W-1:0]     mem_addr_i,
    input  logic [DATA_W-1:0]     mem_rdata_i,
    input  logic [REG_ADDR_W-1:0] reg_waddr_i,
    output logic                  busy_o,
    output logic                  ready_o,
    output logic                  tmo_o,
    output logic [REG_ADDR_W-1:0] reg_waddr_o,
    output logic [CH_W-1:0]       ch_o
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_ARM  = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_DONE = 3'd3;
    localparam logic [2:0] S_TOUT = 3'd4;

    localparam logic [CH_W:0]    NUM_CH_V = (CH_W + 1)'(NUM_CH);
    localparam logic [CH_W-1:0]  MAX_CH   = CH_W'(NUM_CH - 1);
    localparam logic [TMO_W-1:0] TMO_ONE  = {{(TMO_W - 1){1'b0}}, 1'b1};

    logic [2:0]        state;
    logic [BIT_W-1:0]  bit_q;
    logic              pol_q;
    logic [TMO_W-1:0]  tmo_q;
    logic [TMO_W-1:0]  cnt;

    logic [CH_W-1:0]   ch_clamped;
    logic [ADDR_W-1:0] ch_addr;
    logic              hit_wr;
    logic              hit_rd;
    logic              match;
    logic              tmo_last;

    always_comb begin
        ch_clamped = ({1'b0, ch_sel_i} >= NUM_CH_V) ? MAX_CH : ch_sel_i;
        // The channel address wraps silently at ADDR_W bits.
        ch_addr    = BASE_ADDR + (ADDR_W'(ch_o) * CH_STRIDE);
        hit_wr     = mem_req_i &  mem_we_i & (mem_addr_i == ch_addr);
        hit_rd     = mem_req_i & ~mem_we_i & (mem_addr_i == ch_addr);
        match      = hit_rd & (mem_rdata_i[bit_q] == pol_q);
        // A timeout of 0 disables expiry entirely.
        tmo_last   = (tmo_q != '0) && (cnt == (tmo_q - TMO_ONE));
    end

    // The outputs decode the registered state directly, so reset clears them at once.
    assign busy_o  = (state == S_ARM) || (state == S_WAIT);
    assign ready_o = (state == S_DONE);
    assign tmo_o   = (state == S_TOUT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            ch_o        <= '0;
            bit_q       <= '0;
            pol_q       <= 1'b0;
            tmo_q       <= '0;
            cnt         <= '0;
            reg_waddr_o <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_i && !abort_i) begin
                        ch_o  <= ch_clamped;
                        bit_q <= done_bit_i;
                        pol_q <= done_pol_i;
                        tmo_q <= tmo_i;
                        state <= S_ARM;
                    end
                end
                S_ARM: begin
                    if (abort_i) begin
                        state <= S_IDLE;
                    end else if (hit_wr) begin
                        reg_waddr_o <= reg_waddr_i;
                        cnt         <= '0;
                        state       <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // Priority: abort, then match, then re-arming store, then timeout.
                    if (abort_i) begin
                        state <= S_IDLE;
                    end else if (match) begin
                        state <= S_DONE;
                    end else if (hit_wr) begin
                        reg_waddr_o <= reg_waddr_i;
                        cnt         <= '0;
                    end else if (tmo_last) begin
                        state <= S_TOUT;
                    end else if (cnt != '1) begin
                        cnt <= cnt + TMO_ONE;
                    end
                end
                S_DONE, S_TOUT: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_poll_waiter.sv
// tb_mmio_poll_waiter
//   Directed bench for mmio_poll_waiter, instantiated with three channels so that
//   channel clamping can be exercised. Each ready/timeout pulse is expected to
//   match the next entry in exp_q. An entry is packed as {tmo, ready, reg, ch}.
module tb_mmio_poll_waiter;

    localparam int NUM_CH = 3;
    localparam int CH_W   = 2;
    localparam int EXP_W  = 2 + 5 + CH_W;

    logic        clk;
    logic        rst;
    logic        start_i;
    logic        abort_i;
    logic [1:0]  ch_sel_i;
    logic [4:0]  done_bit_i;
    logic        done_pol_i;
    logic [15:0] tmo_i;
    logic        mem_req_i;
    logic        mem_we_i;
    logic [31:0] mem_addr_i;
    logic [31:0] mem_rdata_i;
    logic [4:0]  reg_waddr_i;
    logic        busy_o;
    logic        ready_o;
    logic        tmo_o;
    logic [4:0]  reg_waddr_o;
    logic [1:0]  ch_o;

    int total = 0;
    int bad   = 0;
    logic [EXP_W-1:0] exp_q[$];

    mmio_poll_waiter #(.NUM_CH(NUM_CH)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .abort_i(abort_i),
        .ch_sel_i(ch_sel_i), .done_bit_i(done_bit_i), .done_pol_i(done_pol_i),
        .tmo_i(tmo_i), .mem_req_i(mem_req_i), .mem_we_i(mem_we_i),
        .mem_addr_i(mem_addr_i), .mem_rdata_i(mem_rdata_i), .reg_waddr_i(reg_waddr_i),
        .busy_o(busy_o), .ready_o(ready_o), .tmo_o(tmo_o),
        .reg_waddr_o(reg_waddr_o), .ch_o(ch_o)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- checking helpers ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [EXP_W-1:0] pack(input logic t, input logic r,
                                              input logic [4:0] rd, input logic [1:0] ch);
        return {t, r, rd, ch};
    endfunction

    // Pops one expected entry per observed pulse.
    always @(negedge clk) begin
        logic [EXP_W-1:0] e;
        if (!rst && (ready_o || tmo_o)) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_pulse", 32'(pack(tmo_o, ready_o, reg_waddr_o, ch_o)), 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("pulse", 32'(pack(tmo_o, ready_o, reg_waddr_o, ch_o)), 32'(e));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        start_i     = 1'b0;
        abort_i     = 1'b0;
        mem_req_i   = 1'b0;
        mem_we_i    = 1'b0;
        mem_addr_i  = '0;
        mem_rdata_i = '0;
        reg_waddr_i = '0;
    endtask

    task automatic do_start(input logic [1:0] ch, input logic [4:0] b, input logic p,
                            input logic [15:0] t);
        start_i = 1'b1; ch_sel_i = ch; done_bit_i = b; done_pol_i = p; tmo_i = t;
        cyc();
        clear_inputs();
    endtask

    task automatic do_store(input logic [31:0] a, input logic [4:0] rd);
        mem_req_i = 1'b1; mem_we_i = 1'b1; mem_addr_i = a; reg_waddr_i = rd;
        cyc();
        clear_inputs();
    endtask

    task automatic do_load(input logic [31:0] a, input logic [31:0] d);
        mem_req_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = a; mem_rdata_i = d;
        cyc();
        clear_inputs();
    endtask

    task automatic do_abort();
        abort_i = 1'b1;
        cyc();
        clear_inputs();
    endtask

    task automatic chk_flags(input string tag, input logic b, input logic r, input logic t);
        chk({tag, "_busy"},  32'(busy_o),  32'(b));
        chk({tag, "_ready"}, 32'(ready_o), 32'(r));
        chk({tag, "_tmo"},   32'(tmo_o),   32'(t));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst = 1'b1;
        ch_sel_i = '0; done_bit_i = '0; done_pol_i = 1'b0; tmo_i = '0;
        clear_inputs();
        repeat (2) cyc();
        rst = 1'b0;
        chk_flags("reset", 1'b0, 1'b0, 1'b0);
        chk("reset_reg", 32'(reg_waddr_o), 32'd0);
        chk("reset_ch", 32'(ch_o), 32'd0);

        // 1: ch0 bit0 pol0, loads 1,1,0
        do_start(2'd0, 5'd0, 1'b0, 16'd0);
        chk_flags("t1_arm", 1'b1, 1'b0, 1'b0);
        do_load(32'h7004_0000, 32'h0);            // loads are ignored in ARM
        chk_flags("t1_arm_load", 1'b1, 1'b0, 1'b0);
        do_store(32'h7004_0000, 5'd5);
        chk("t1_reg", 32'(reg_waddr_o), 32'd5);
        do_load(32'h7004_0000, 32'h1);
        do_load(32'h7004_0000, 32'h1);
        chk_flags("t1_nomatch", 1'b1, 1'b0, 1'b0);
        exp_q.push_back(pack(1'b0, 1'b1, 5'd5, 2'd0));
        do_load(32'h7004_0000, 32'h0);
        chk_flags("t1_done", 1'b0, 1'b1, 1'b0);
        cyc();
        chk_flags("t1_after", 1'b0, 1'b0, 1'b0);

        // 2: ch2 bit7 pol1; other channel's traffic ignored
        do_start(2'd2, 5'd7, 1'b1, 16'd0);
        chk("t2_ch", 32'(ch_o), 32'd2);
        do_store(32'h7004_0000, 5'd3);            // wrong channel, stays in ARM
        chk_flags("t2_wrong_store", 1'b1, 1'b0, 1'b0);
        do_store(32'h7004_0200, 5'd9);
        chk("t2_reg", 32'(reg_waddr_o), 32'd9);
        do_load(32'h7004_0000, 32'h80);
        do_load(32'h7004_0000, 32'h80);
        do_store(32'h7004_0000, 5'd3);
        chk("t2_reg_kept", 32'(reg_waddr_o), 32'd9);
        do_load(32'h7004_0200, 32'h7F);
        chk_flags("t2_wait", 1'b1, 1'b0, 1'b0);
        exp_q.push_back(pack(1'b0, 1'b1, 5'd9, 2'd2));
        do_load(32'h7004_0200, 32'h80);
        chk_flags("t2_done", 1'b0, 1'b1, 1'b0);
        chk("t2_ch_done", 32'(ch_o), 32'd2);
        cyc();

        // 3a: tmo=3, no match -> tmo_o exactly 3 cycles after WAIT entry
        do_start(2'd1, 5'd0, 1'b1, 16'd3);
        exp_q.push_back(pack(1'b1, 1'b0, 5'd12, 2'd1));
        do_store(32'h7004_0100, 5'd12);
        do_load(32'h7004_0100, 32'h0);
        chk_flags("t3_c1", 1'b1, 1'b0, 1'b0);
        do_load(32'h7004_0100, 32'h0);
        chk_flags("t3_c2", 1'b1, 1'b0, 1'b0);
        do_load(32'h7004_0100, 32'h0);
        chk_flags("t3_c3", 1'b0, 1'b0, 1'b1);
        cyc();
        chk_flags("t3_after", 1'b0, 1'b0, 1'b0);

        // 3b: a store in WAIT re-latches the register and restarts the count
        do_start(2'd1, 5'd0, 1'b1, 16'd3);
        do_store(32'h7004_0100, 5'd12);
        cyc();
        cyc();
        exp_q.push_back(pack(1'b1, 1'b0, 5'd13, 2'd1));
        do_store(32'h7004_0100, 5'd13);
        chk("t3b_reg", 32'(reg_waddr_o), 32'd13);
        cyc();
        cyc();
        chk_flags("t3b_c2", 1'b1, 1'b0, 1'b0);
        cyc();
        chk_flags("t3b_c3", 1'b0, 1'b0, 1'b1);
        cyc();

        // 4: channel 3 clamps to 2; match on the expiry cycle wins
        do_start(2'd3, 5'd31, 1'b0, 16'd3);
        chk("t4_clamp", 32'(ch_o), 32'd2);
        do_store(32'h7004_0200, 5'd20);
        cyc();
        cyc();
        chk_flags("t4_pre", 1'b1, 1'b0, 1'b0);
        exp_q.push_back(pack(1'b0, 1'b1, 5'd20, 2'd2));
        do_load(32'h7004_0200, 32'h7FFF_FFFF);
        chk_flags("t4_match_wins", 1'b0, 1'b1, 1'b0);
        cyc();
        chk_flags("t4_after", 1'b0, 1'b0, 1'b0);

        // 5: aborts, abort beats start in IDLE, start ignored in WAIT
        do_start(2'd1, 5'd0, 1'b1, 16'd0);
        chk_flags("t5_arm", 1'b1, 1'b0, 1'b0);
        do_abort();
        chk_flags("t5_abort_arm", 1'b0, 1'b0, 1'b0);
        start_i = 1'b1; abort_i = 1'b1; ch_sel_i = 2'd2;
        cyc();
        clear_inputs();
        chk_flags("t5_idle_abort", 1'b0, 1'b0, 1'b0);
        chk("t5_ch_kept", 32'(ch_o), 32'd1);
        do_start(2'd1, 5'd0, 1'b1, 16'd0);
        do_store(32'h7004_0100, 5'd7);
        do_start(2'd0, 5'd5, 1'b0, 16'd2);       // must be ignored
        chk("t5_ch_wait", 32'(ch_o), 32'd1);
        do_load(32'h7004_0100, 32'h0);
        chk_flags("t5_still_wait", 1'b1, 1'b0, 1'b0);
        do_abort();
        chk_flags("t5_abort_wait", 1'b0, 1'b0, 1'b0);
        cyc();
        chk_flags("t5_quiet", 1'b0, 1'b0, 1'b0);

        // 6: asynchronous reset mid-WAIT, then a normal transaction
        do_start(2'd0, 5'd0, 1'b1, 16'd0);
        do_store(32'h7004_0000, 5'd4);
        chk("t6_reg_pre", 32'(reg_waddr_o), 32'd4);
        #2 rst = 1'b1;
        #1;
        chk_flags("t6_async", 1'b0, 1'b0, 1'b0);
        chk("t6_reg", 32'(reg_waddr_o), 32'd0);
        chk("t6_ch", 32'(ch_o), 32'd0);
        cyc();
        rst = 1'b0;
        do_start(2'd2, 5'd3, 1'b1, 16'd0);
        do_store(32'h7004_0200, 5'd17);
        exp_q.push_back(pack(1'b0, 1'b1, 5'd17, 2'd2));
        do_load(32'h7004_0200, 32'h8);
        chk_flags("t6_done", 1'b0, 1'b1, 1'b0);
        chk("t6_reg_done", 32'(reg_waddr_o), 32'd17);
        cyc();

        chk("pending_pulses", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
